// File: rtl/ahb_access_scheduler.sv
// ahb_access_scheduler: arbitrates Sobel read and writeback requests onto a single AHB master port
module ahb_access_scheduler #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rd_req,
  input  logic [19:0] rd_pixNum,
  output logic        rd_done,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  input  logic [19:0] wr_pixNum,
  input  logic [31:0] wr_data,
  output logic        wr_done,
  output logic        err,
  output logic [1:0]  mode,
  output logic [19:0] pixNum,
  output logic [31:0] wdata,
  output logic [1:0]  size,
  output logic        startAddr_sel,
  input  logic        data_feedback,
  input  logic [31:0] rdata,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_wr_q, last_wr_d;
  logic [19:0] pix_q, pix_d;
  logic [31:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic [1:0]  size_q, size_d;
  logic        sel_q, sel_d, rd_done_q, rd_done_d, wr_done_q, wr_done_d, err_q, err_d;
  // state and output registers; reset aborts any transfer without a done pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_wr_q <= 1'b1;
      pix_q     <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      size_q    <= '0;
      sel_q     <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      pix_q     <= pix_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      size_q    <= size_d;
      sel_q     <= sel_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
    end
  end
  // next state: round-robin grant in IDLE, one-cycle issue, wait for feedback or timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    pix_d     = pix_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    size_d    = size_q;
    sel_d     = sel_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req && (!wr_req || last_wr_q)) begin
          state_d   = ISSUE_RD;
          last_wr_d = 1'b0;
          pix_d     = rd_pixNum;
          size_d    = 2'b10;
          sel_d     = 1'b0;
        end else if (wr_req) begin
          state_d   = ISSUE_WR;
          last_wr_d = 1'b1;
          pix_d     = wr_pixNum;
          wdata_d   = wr_data;
          size_d    = 2'b00;
          sel_d     = 1'b1;
        end
      end
      ISSUE_RD: begin
        state_d = WAIT_RD;
        cnt_d   = '0;
      end
      ISSUE_WR: begin
        state_d = WAIT_WR;
        cnt_d   = '0;
      end
      WAIT_RD: begin
        if (data_feedback || cnt_q == LAST) begin
          state_d   = IDLE;
          rd_done_d = 1'b1;
          err_d     = !data_feedback;
          rd_data_d = data_feedback ? rdata : '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      WAIT_WR: begin
        if (data_feedback || cnt_q == LAST) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
          err_d     = !data_feedback;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign mode          = state_q == ISSUE_RD ? 2'b01 : state_q == ISSUE_WR ? 2'b10 : 2'b00;
  assign busy          = state_q != IDLE;
  assign pixNum        = pix_q;
  assign wdata         = wdata_q;
  assign size          = size_q;
  assign startAddr_sel = sel_q;
  assign rd_data       = rd_data_q;
  assign rd_done       = rd_done_q;
  assign wr_done       = wr_done_q;
  assign err           = err_q;
endmodule
